// File: rtl/bbot_quadrature_decoder.sv
// Quadrature encoder decoder: synchronised, glitch-filtered 4x decode with
// position count, direction, sticky illegal-transition flag and windowed velocity.
module bbot_quadrature_decoder #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      FILTER_LEN  = 3,
  parameter int unsigned      VEL_WINDOW  = 10000,
  parameter logic [WIDTH-1:0] RESET_COUNT = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             A,
  input  logic             B,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clear,
  output logic [WIDTH-1:0] count,
  output logic             direction,
  output logic             error,
  output logic [WIDTH-1:0] velocity,
  output logic             vel_valid
);

  localparam int unsigned      WCW       = $clog2(VEL_WINDOW);
  localparam logic [WCW-1:0]   WIN_LAST  = WCW'(VEL_WINDOW - 1);
  localparam logic [3:0]       FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [WIDTH-1:0] ACC_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] ACC_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_INC,
    STEP_DEC,
    STEP_ERR
  } step_e;

  logic [1:0]       sync1_q, sync1_d;
  logic [1:0]       sync2_q, sync2_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       filt_prev_q, filt_prev_d;
  logic [3:0]       fcnt_q, fcnt_d;
  step_e            step_q, step_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] vel_q, vel_d;
  logic             vv_q, vv_d;
  logic [WCW-1:0]   win_q, win_d;

  always_comb begin
    sync1_d     = {A, B};
    sync2_d     = sync1_q;
    filt_d      = filt_q;
    fcnt_d      = '0;
    filt_prev_d = filt_q;
    // The run counter restarts whenever the synchronised level agrees with
    // the filtered one, so only an unbroken run of FILTER_LEN samples is accepted.
    if (sync2_q != filt_q) begin
      if (fcnt_q == FILT_LAST) filt_d = sync2_q;
      else                     fcnt_d = fcnt_q + 4'd1;
    end

    unique case ({filt_prev_q, filt_q})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_d = STEP_INC;
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_d = STEP_DEC;
      4'b0011, 4'b1100, 4'b1001, 4'b0110: step_d = STEP_ERR;
      default:                            step_d = STEP_NONE;
    endcase

    count_d = count_q;
    if (load)                      count_d = load_value;
    else if (clear)                count_d = RESET_COUNT;
    else if (step_q == STEP_INC)   count_d = count_q + WIDTH'(1);
    else if (step_q == STEP_DEC)   count_d = count_q - WIDTH'(1);

    dir_d = dir_q;
    if (step_q == STEP_INC)      dir_d = 1'b1;
    else if (step_q == STEP_DEC) dir_d = 1'b0;

    err_d = err_q;
    if (err_clear)          err_d = 1'b0;
    if (step_q == STEP_ERR) err_d = 1'b1;

    acc_step = acc_q;
    if (step_q == STEP_INC && acc_q != ACC_MAX)      acc_step = acc_q + WIDTH'(1);
    else if (step_q == STEP_DEC && acc_q != ACC_MIN) acc_step = acc_q - WIDTH'(1);

    if (win_q == WIN_LAST) begin
      vel_d = acc_step;
      vv_d  = 1'b1;
      acc_d = '0;
      win_d = '0;
    end else begin
      vel_d = vel_q;
      vv_d  = 1'b0;
      acc_d = acc_step;
      win_d = win_q + WCW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      fcnt_q      <= '0;
      step_q      <= STEP_NONE;
      count_q     <= RESET_COUNT;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      vel_q       <= '0;
      vv_q        <= 1'b0;
      win_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      fcnt_q      <= fcnt_d;
      step_q      <= step_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      vel_q       <= vel_d;
      vv_q        <= vv_d;
      win_q       <= win_d;
    end
  end

  assign count     = count_q;
  assign direction = dir_q;
  assign error     = err_q;
  assign velocity  = vel_q;
  assign vel_valid = vv_q;

endmodule

// File: tb/tb_bbot_quadrature_decoder.sv
// Self-checking bench for bbot_quadrature_decoder: vector table, directed corner
// sequences, and randomized steps checked against a position/timestamp model.
module tb_bbot_quadrature_decoder;

  localparam int unsigned W  = 32;
  localparam int unsigned FL = 3;
  localparam int unsigned VW = 100;
  localparam logic [31:0] RC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset_l, A, B, clear, load, err_clear;
  logic [31:0] load_value;
  logic [31:0] count, velocity;
  logic        direction, error, vel_valid;

  always #5 clock = ~clock;

  bbot_quadrature_decoder #(
    .WIDTH(W), .FILTER_LEN(FL), .VEL_WINDOW(VW), .RESET_COUNT(RC)
  ) dut (
    .clock(clock), .reset_l(reset_l), .A(A), .B(B), .clear(clear), .load(load),
    .load_value(load_value), .err_clear(err_clear), .count(count),
    .direction(direction), .error(error), .velocity(velocity), .vel_valid(vel_valid)
  );

  int applied = 0;
  int miscompares = 0;
  longint edge_no = 0;
  always @(posedge clock) edge_no++;

  // Model: gray position of the encoder, expected count/direction/error, and
  // a queue of net steps stamped with the clock edge at which they land.
  logic [1:0]  pos_m;
  logic [31:0] cnt_m;
  logic        dir_m, err_m;
  typedef struct { longint land; int d; } ev_t;
  ev_t    evq[$];
  longint prev_e;
  bit     mon_en = 1'b0;

  typedef enum { OP_LVL, OP_LOAD, OP_CLEAR, OP_ERRCLR, OP_IDLE } op_e;
  typedef struct {
    op_e op; logic [1:0] ab; logic [31:0] val; int hold;
    logic [31:0] e_cnt; logic e_dir; logic e_err;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); @(negedge clock); end
  endtask

  function automatic logic [1:0] pos2ab(input logic [1:0] p);
    case (p)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] ab2pos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Drive a new encoder level; the change lands on count 7 edges later.
  task automatic move(input logic [1:0] np);
    logic [1:0] d;
    d = np - pos_m;
    {A, B} = pos2ab(np);
    if (d == 2'd1) begin
      cnt_m = cnt_m + 32'd1; dir_m = 1'b1; evq.push_back('{edge_no + 7, 1});
    end else if (d == 2'd3) begin
      cnt_m = cnt_m - 32'd1; dir_m = 1'b0; evq.push_back('{edge_no + 7, -1});
    end else if (d == 2'd2) begin
      err_m = 1'b1;
    end
    pos_m = np;
  endtask

  task automatic check_state(input string name);
    check({name, "_count"}, count, cnt_m);
    check({name, "_dir"}, {31'b0, direction}, {31'b0, dir_m});
    check({name, "_err"}, {31'b0, error}, {31'b0, err_m});
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_count"}, count, RC);
    check({name, "_dir"}, {31'b0, direction}, 32'd0);
    check({name, "_err"}, {31'b0, error}, 32'd0);
    check({name, "_vel"}, velocity, 32'd0);
    check({name, "_vv"}, {31'b0, vel_valid}, 32'd0);
  endtask

  task automatic wait_vv(input string name);
    for (int i = 0; i < 150; i++) begin
      if (vel_valid) break;
      tick(1);
    end
    check(name, {31'b0, vel_valid}, 32'd1);
  endtask

  // Every velocity update must equal the steps landed since the previous
  // update, and updates must be exactly one window apart.
  always @(negedge clock) begin
    if (mon_en && vel_valid) begin
      int sum;
      sum = 0;
      while (evq.size() > 0 && evq[0].land <= edge_no) begin
        sum += evq[0].d;
        void'(evq.pop_front());
      end
      check("vel_model", velocity, 32'(sum));
      check("vel_spacing", 32'(edge_no - prev_e), VW);
      prev_e = edge_no;
    end
  end

  initial begin
    tbl = '{
      '{OP_LVL,    2'b10, 32'h0,         8,   32'h8000_0001, 1'b1, 1'b0},
      '{OP_LVL,    2'b11, 32'h0,         8,   32'h8000_0002, 1'b1, 1'b0},
      '{OP_LVL,    2'b01, 32'h0,         8,   32'h8000_0003, 1'b1, 1'b0},
      '{OP_LVL,    2'b00, 32'h0,         8,   32'h8000_0004, 1'b1, 1'b0},
      '{OP_LOAD,   2'b00, 32'hFFFF_FFFF, 3,   32'hFFFF_FFFF, 1'b1, 1'b0},
      '{OP_LVL,    2'b10, 32'h0,         8,   32'h0000_0000, 1'b1, 1'b0},
      '{OP_LVL,    2'b00, 32'h0,         8,   32'hFFFF_FFFF, 1'b0, 1'b0},
      '{OP_LVL,    2'b11, 32'h0,         8,   32'hFFFF_FFFF, 1'b0, 1'b1},
      '{OP_IDLE,   2'b00, 32'h0,         100, 32'hFFFF_FFFF, 1'b0, 1'b1},
      '{OP_ERRCLR, 2'b00, 32'h0,         3,   32'hFFFF_FFFF, 1'b0, 1'b0},
      '{OP_LVL,    2'b00, 32'h0,         8,   32'hFFFF_FFFF, 1'b0, 1'b1},
      '{OP_ERRCLR, 2'b00, 32'h0,         3,   32'hFFFF_FFFF, 1'b0, 1'b0},
      '{OP_CLEAR,  2'b00, 32'h0,         3,   32'h8000_0000, 1'b0, 1'b0},
      '{OP_LVL,    2'b01, 32'h0,         8,   32'h7FFF_FFFF, 1'b0, 1'b0}
    };

    reset_l = 1'b0; A = 1'b0; B = 1'b0; clear = 1'b0; load = 1'b0;
    err_clear = 1'b0; load_value = '0;
    pos_m = 2'd0; cnt_m = RC; dir_m = 1'b0; err_m = 1'b0;
    @(negedge clock);
    tick(3);
    check_reset_vals("rst");
    reset_l = 1'b1; prev_e = edge_no; mon_en = 1'b1;
    tick(1);
    check_reset_vals("rst_rel");

    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_LVL:    begin move(ab2pos(tbl[i].ab)); tick(tbl[i].hold); end
        OP_LOAD:   begin
          load_value = tbl[i].val; load = 1'b1; tick(1); load = 1'b0;
          cnt_m = tbl[i].val; tick(tbl[i].hold - 1);
        end
        OP_CLEAR:  begin clear = 1'b1; tick(1); clear = 1'b0; cnt_m = RC; tick(tbl[i].hold - 1); end
        OP_ERRCLR: begin err_clear = 1'b1; tick(1); err_clear = 1'b0; err_m = 1'b0; tick(tbl[i].hold - 1); end
        default:   tick(tbl[i].hold);
      endcase
      check($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("vec%0d_dir", i), {31'b0, direction}, {31'b0, tbl[i].e_dir});
      check($sformatf("vec%0d_err", i), {31'b0, error}, {31'b0, tbl[i].e_err});
    end

    // err_clear coinciding with a new illegal transition keeps error set
    move(2'd1);
    tick(6);
    err_clear = 1'b1; tick(1); err_clear = 1'b0;
    check_state("errclr_race");
    err_clear = 1'b1; tick(1); err_clear = 1'b0; err_m = 1'b0;
    check_state("errclr_after");

    // exact latency: count moves on the 7th edge after the drive
    move(2'd2);
    tick(6);
    check("lat_before", count, cnt_m - 32'd1);
    tick(1);
    check("lat_at", count, cnt_m);

    // 2-clock glitch is discarded; a 3-clock pulse is two real steps
    A = 1'b0; tick(2); A = 1'b1; tick(10);
    check_state("glitch2");
    move(2'd3); tick(3); move(2'd2); tick(10);
    check_state("pulse3");

    // clear in the same clock as a forward step
    load_value = 32'h1234_5678; load = 1'b1; tick(1); load = 1'b0; cnt_m = 32'h1234_5678;
    move(2'd3);
    tick(6);
    check("clr_step_pre", count, 32'h1234_5678);
    clear = 1'b1; tick(1); clear = 1'b0; cnt_m = RC;
    check_state("clr_step");

    // 7 forward + 2 reverse inside one window
    wait_vv("vel_wait_start");
    for (int i = 0; i < 7; i++) begin move(pos_m + 2'd1); tick(7); end
    for (int i = 0; i < 2; i++) begin move(pos_m - 2'd1); tick(7); end
    tick(1);
    wait_vv("vel_wait_end");
    check("vel_window", velocity, 32'd5);
    tick(1);
    check("vel_pulse", {31'b0, vel_valid}, 32'd0);
    check_state("vel_state");

    // reset mid-window with encoder at 11: decoded as illegal 00->11 afterwards
    tick(37);
    mon_en = 1'b0;
    reset_l = 1'b0; A = 1'b1; B = 1'b1;
    tick(3);
    check_reset_vals("rst11");
    reset_l = 1'b1; evq.delete(); prev_e = edge_no; mon_en = 1'b1;
    pos_m = 2'd2; cnt_m = RC; dir_m = 1'b0; err_m = 1'b1;
    tick(8);
    check_state("init11");

    for (int it = 0; it < 80; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 40) begin
        move(pos_m + 2'd1); tick($urandom_range(7, 12));
      end else if (r < 70) begin
        move(pos_m - 2'd1); tick($urandom_range(7, 12));
      end else if (r < 78) begin
        move(pos_m + 2'd2); tick($urandom_range(7, 12));
      end else if (r < 92) begin
        logic [1:0] ab;
        ab = pos2ab(pos_m);
        if ($urandom_range(0, 1) == 0) ab[1] = ~ab[1];
        else                           ab[0] = ~ab[0];
        {A, B} = ab;
        tick($urandom_range(1, 2));
        {A, B} = pos2ab(pos_m);
        tick(8);
      end else begin
        err_clear = 1'b1; tick(1); err_clear = 1'b0; err_m = 1'b0; tick(2);
      end
      check_state($sformatf("rnd%0d", it));
    end

    tick(2 * VW + 10);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/bbot_quadrature_decoder.md
BBOT_QUADRATURE_DECODER -- requirements
Module: bbot_quadrature_decoder

Interface
REQ-001 Parameter WIDTH, default 32: count and velocity width in bits, legal range 8..32.
REQ-002 Parameter FILTER_LEN, default 3: consecutive identical synchronised samples needed to accept a new A/B level, legal range 1..15.
REQ-003 Parameter VEL_WINDOW, default 10000: velocity sample window in clocks, legal range 2..2^24.
REQ-004 Parameter RESET_COUNT, default 2^(WIDTH-1): count value after reset and after clear.
REQ-005 clock  in  1  single system clock; all state on rising edge.
REQ-006 reset_l  in  1  asynchronous, active-low reset.
REQ-007 A, B  in  1  asynchronous encoder channels.
REQ-008 clear  in  1  synchronous, sets count to RESET_COUNT.
REQ-009 load  in  1  synchronous, sets count to load_value.
REQ-010 load_value  in  WIDTH  preset value.
REQ-011 err_clear  in  1  synchronous, clears error.
REQ-012 count  out  WIDTH  registered position count.
REQ-013 direction  out  1  1 = last valid step incremented, 0 = decremented.
REQ-014 error  out  1  sticky illegal-transition flag.
REQ-015 velocity  out  WIDTH  signed two's-complement net steps in last completed window.
REQ-016 vel_valid  out  1  one-clock pulse when velocity updates.

Function
REQ-017 A and B shall each pass through a two-flop synchroniser before any use.
REQ-018 The filtered state {A,B} shall update only after a synchronised value differs from it and holds for FILTER_LEN consecutive clocks; shorter pulses are discarded.
REQ-019 Decode shall be 4x: each change of filtered {A,B} is one event.
REQ-020 Forward sequence 00->10->11->01->00 ({A,B}) shall increment count by 1 and set direction = 1.
REQ-021 Reverse sequence 00->01->11->10->00 shall decrement count by 1 and set direction = 0.
REQ-022 A change of both bits in one filtered update (00<->11, 10<->01) shall not change count or direction and shall set error.
REQ-023 error shall remain 1 until err_clear or reset; simultaneous err_clear and new illegal transition leaves error = 1.
REQ-024 count shall wrap modulo 2^WIDTH in both directions, with no flag.
REQ-025 Priority in one clock: load > clear > step; a step coinciding with load or clear is dropped from count but still counts toward velocity.
REQ-026 Latency: a clean input edge held stable shall be reflected on count exactly FILTER_LEN+3 clocks after the first rising edge that samples it.
REQ-027 A free-running window counter shall divide the clock by VEL_WINDOW; the velocity accumulator adds +1/-1 per valid step.
REQ-028 On the last clock of each window, velocity <= accumulator including that clock's step; vel_valid = 1 for that one clock; accumulator restarts at 0.
REQ-029 The accumulator shall saturate at the signed WIDTH-bit limits rather than wrap.
REQ-030 load and clear shall not affect the velocity window or accumulator.

Reset
REQ-031 While reset_l = 0: count = RESET_COUNT, direction = 0, error = 0, velocity = 0, vel_valid = 0, synchronisers, filter state and filtered {A,B} = 00, window counter and accumulator = 0.
REQ-032 Reset asserted mid-window or mid-filter shall discard all partial state; after release, the first window is a full VEL_WINDOW clocks.
REQ-033 If A/B are not 00 at reset release, the first filtered update shall be decoded as a normal transition from 00; a nonzero initial state of 11 shall therefore set error.

Verification
REQ-034 WIDTH = 32, FILTER_LEN = 3: one forward cycle 00,10,11,01,00 with each state held 8 clocks -> count 0x80000004, direction = 1, error = 0; the first update occurs 6 clocks after the first edge.
REQ-035 2-clock glitch on A with FILTER_LEN = 3 -> count and error unchanged.
REQ-036 load_value 0xFFFFFFFF via load, then one forward step -> count 0x00000000; then one reverse step -> 0xFFFFFFFF, direction = 0.
REQ-037 Force 00->11 in one filtered update -> count unchanged, error = 1; error holds through 100 clocks, then clears on err_clear.
REQ-038 VEL_WINDOW = 100, 7 forward and 2 reverse steps inside one window -> velocity = 5, vel_valid pulses once for 1 clock at window end.
REQ-039 Assert clear and a forward step in the same clock -> count = RESET_COUNT; the window's velocity still includes +1.
